parity_frame_tx: RTL
====================

# parity_frame_tx

Serial frame transmitter that sits directly downstream of the 8-bit parity generator. It accepts a byte together with the generator's parity bit through a valid/ready handshake. It checks the supplied parity against its own even-parity computation and reports mismatches. It then shifts out a framed serial word: start bit, 8 data bits LSB first, the supplied parity bit, and a stop bit.

## Interface
Parameters:
- CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data  input  8  byte to send; sampled on the accept edge only.
- parity  input  1  parity bit from the upstream generator; sampled on the accept edge.
- valid  input  1  upstream has a byte plus parity on data/parity.
- ready  output  1  high only in IDLE; transfer occurs on a clock edge where valid && ready.
- tx  output  1  serial line, registered; idle level 1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse marking frame completion.
- par_err  output  1  one-cycle pulse when the supplied parity ≠ ^data (even parity).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, ready=1.
  - On valid && ready: latch data into the shift register and parity into a parity register.
  - Register par_err = parity ^ (^data).
  - Load tx=0 and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift_reg[0] for CLKS_PER_BIT cycles per bit.
  - Shift right after each bit.
  - A 3-bit bit index counts 0..7; after bit 7, go to PARITY.
- PARITY:
  - tx = latched parity bit for CLKS_PER_BIT cycles.
  - The bit is transmitted exactly as supplied, even when par_err fired; it is never corrected.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Width is $clog2(CLKS_PER_BIT), with a minimum of 1 bit.
  - With CLKS_PER_BIT=1, every bit lasts exactly one cycle.
- valid is ignored while busy. data and parity may change freely after the accept edge.
- Reset values: state=IDLE, tx=1, ready=1, busy=0, done=0, par_err=0, counters and shift register 0.
- Reset mid-frame: tx returns to 1 asynchronously and the frame is discarded. No done and no par_err are produced for the aborted frame.

## Timing
- Latency: tx falls on the same edge that accepts the byte, so the start bit is visible in the first cycle after acceptance.
- Frame length: 11 × CLKS_PER_BIT cycles from the accept edge to the edge that returns the block to IDLE.
- par_err: high for exactly the first cycle after the accept edge (coincident with the first START cycle).
- done: high for exactly the first IDLE cycle after STOP; ready is also high in that cycle.
- Back-to-back (valid held high): the next byte is accepted in the done cycle. Between frames, tx is 1 for exactly one cycle (the done cycle) plus the stop bit.
- ready and busy are decoded from the state register only; there is no combinational path from valid.

## Test plan
- Reset and idle:
  - Assert rst for 3 cycles, release, keep valid=0 for 20 cycles.
  - Required: tx=1, ready=1, busy=0, done=0, par_err=0 throughout.
- Basic frame, CLKS_PER_BIT=4:
  - Send data=0x07, parity=1.
  - Required: tx holds each level for 4 cycles in the order 0 | 1,1,1,0,0,0,0,0 | 1 | 1.
  - done pulses 44 cycles after the accept edge; par_err never asserts.
- Parity mismatch from a stuck-at-0 generator:
  - Send data=0x01, parity=0. Required: par_err pulses once in the cycle after acceptance, and the transmitted parity bit is 0.
  - Send data=0xFF, parity=0. Required: no par_err.
- Back-to-back:
  - Hold valid=1 with data=0xAA (parity 0), then 0x55 (parity 0).
  - Required: the second accept occurs in the done cycle of the first frame.
  - The second start bit begins one cycle after done; the payloads are 0,1,0,1,0,1,0,1 and then 1,0,1,0,1,0,1,0.
- Reset mid-frame:
  - Assert rst during DATA bit 3 of 0x55.
  - Required: tx=1 immediately; no done or par_err; after release, ready=1 and the next frame (0x03, parity 0) is transmitted correctly.
- CLKS_PER_BIT=1 build:
  - Send data=0x80, parity=1.
  - Required: an 11-cycle frame 0,0,0,0,0,0,0,0,1,1,1, with done on the 12th cycle after acceptance.

Source files
------------

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter for the output of an 8-bit even-parity generator.
// Frame on tx: start(0), data[0..7] LSB first, supplied parity bit, stop(1).
// The supplied parity is checked against ^data and a mismatch is flagged on
// par_err, but the bit is always transmitted exactly as supplied.
module parity_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       parity,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       par_err
);

    // Baud counter width, at least one bit so CLKS_PER_BIT=1 still elaborates.
    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              par_err_q, par_err_d;
    logic              bit_end;

    // Last cycle of the current serial bit.
    assign bit_end = (baud_q == BaudLast);

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        par_err_d = 1'b0;

        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                tx_d      = 1'b1;
                baud_d    = '0;
                bit_idx_d = '0;
                if (valid) begin
                    shift_d   = data;
                    par_d     = parity;
                    par_err_d = parity ^ (^data);
                    // Start bit is driven from the accept edge onward.
                    tx_d      = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = par_q;
                        state_d = StParity;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset discards any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            par_err_q <= par_err_d;
        end
    end

    // Handshake/status decoded from the state register only.
    assign ready   = (state_q == StIdle);
    assign busy    = (state_q != StIdle);
    assign tx      = tx_q;
    assign done    = done_q;
    assign par_err = par_err_q;

endmodule
